// File: rtl/soc_test_supervisor_if.sv
// Signal bundle between the test supervisor (slave) and the side that drives
// the SoC LED bus and restart pulse (master).
interface soc_test_supervisor_if #(
    parameter int unsigned LED_WIDTH   = 8,
    parameter int unsigned COUNT_WIDTH = 16
);
    logic                   start;
    logic [LED_WIDTH-1:0]   leds;
    logic                   soc_rst_n;
    logic                   running;
    logic                   done;
    logic                   pass;
    logic                   fail;
    logic                   timeout;
    logic [31:0]            cycle_count;
    logic [COUNT_WIDTH-1:0] change_count;
    logic [LED_WIDTH-1:0]   last_leds;

    modport master (
        output start, leds,
        input  soc_rst_n, running, done, pass, fail, timeout,
        input  cycle_count, change_count, last_leds
    );

    modport slave (
        input  start, leds,
        output soc_rst_n, running, done, pass, fail, timeout,
        output cycle_count, change_count, last_leds
    );
endinterface

// File: rtl/soc_test_supervisor.sv
// SoC test supervisor: sequences the SoC reset, watches the LED bus for a stable
// pass/fail code, counts LED transitions and flags a timeout.
module soc_test_supervisor #(
    parameter int unsigned          LED_WIDTH      = 8,
    parameter int unsigned          RESET_CYCLES   = 3,
    parameter int unsigned          TIMEOUT_CYCLES = 600,
    parameter int unsigned          STABLE_CYCLES  = 4,
    parameter logic [LED_WIDTH-1:0] PASS_CODE      = 8'hAA,
    parameter logic [LED_WIDTH-1:0] FAIL_CODE      = 8'hFF,
    parameter int unsigned          COUNT_WIDTH    = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    soc_test_supervisor_if.slave bus
);

    localparam int unsigned HOLD_W   = $clog2(RESET_CYCLES + 1);
    localparam int unsigned STABLE_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [HOLD_W-1:0]   HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST  = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [31:0]         TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StHold, StRun, StDone} state_e;

    state_e                 state_q, state_d;
    logic                   soc_rst_n_q, soc_rst_n_d;
    logic                   running_q, running_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   fail_q, fail_d;
    logic                   timeout_q, timeout_d;
    logic [31:0]            cycle_count_q, cycle_count_d;
    logic [COUNT_WIDTH-1:0] change_count_q, change_count_d;
    logic [LED_WIDTH-1:0]   last_leds_q, last_leds_d;
    logic [LED_WIDTH-1:0]   leds_q, leds_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [STABLE_W-1:0]    stable_cnt_q, stable_cnt_d;

    logic same;
    logic verdict_pass;
    logic verdict_fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StHold;
            soc_rst_n_q    <= 1'b0;
            running_q      <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
            timeout_q      <= 1'b0;
            cycle_count_q  <= '0;
            change_count_q <= '0;
            last_leds_q    <= '0;
            leds_q         <= '0;
            hold_cnt_q     <= '0;
            stable_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            soc_rst_n_q    <= soc_rst_n_d;
            running_q      <= running_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            fail_q         <= fail_d;
            timeout_q      <= timeout_d;
            cycle_count_q  <= cycle_count_d;
            change_count_q <= change_count_d;
            last_leds_q    <= last_leds_d;
            leds_q         <= leds_d;
            hold_cnt_q     <= hold_cnt_d;
            stable_cnt_q   <= stable_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        soc_rst_n_d    = soc_rst_n_q;
        running_d      = running_q;
        done_d         = done_q;
        pass_d         = pass_q;
        fail_d         = fail_q;
        timeout_d      = timeout_q;
        cycle_count_d  = cycle_count_q;
        change_count_d = change_count_q;
        last_leds_d    = last_leds_q;
        leds_d         = leds_q;
        hold_cnt_d     = hold_cnt_q;
        stable_cnt_d   = stable_cnt_q;

        same         = (leds_q == last_leds_q);
        verdict_pass = same && (stable_cnt_q == STABLE_LAST) && (last_leds_q == PASS_CODE);
        verdict_fail = same && (stable_cnt_q == STABLE_LAST) && (last_leds_q == FAIL_CODE);

        if (bus.start) begin
            // Restart wins over everything; leds_q is cleared too so the first
            // sample of the new run is compared against a clean history.
            state_d        = StHold;
            soc_rst_n_d    = 1'b0;
            running_d      = 1'b0;
            done_d         = 1'b0;
            pass_d         = 1'b0;
            fail_d         = 1'b0;
            timeout_d      = 1'b0;
            cycle_count_d  = '0;
            change_count_d = '0;
            last_leds_d    = '0;
            leds_d         = '0;
            hold_cnt_d     = '0;
            stable_cnt_d   = '0;
        end else begin
            unique case (state_q)
                StHold: begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d     = StRun;
                        soc_rst_n_d = 1'b1;
                        running_d   = 1'b1;
                    end
                end
                StRun: begin
                    leds_d = bus.leds;
                    if (!same) begin
                        last_leds_d  = leds_q;
                        stable_cnt_d = '0;
                        if (!(&change_count_q)) begin
                            change_count_d = change_count_q + COUNT_WIDTH'(1);
                        end
                    end else if (stable_cnt_q != STABLE_LAST) begin
                        stable_cnt_d = stable_cnt_q + STABLE_W'(1);
                    end

                    // The cycle that ends RUN is not added to cycle_count.
                    if (verdict_pass || verdict_fail || (cycle_count_q == TIMEOUT_LAST)) begin
                        state_d   = StDone;
                        running_d = 1'b0;
                        done_d    = 1'b1;
                        pass_d    = verdict_pass;
                        fail_d    = verdict_fail;
                        timeout_d = !verdict_pass && !verdict_fail;
                    end else if (!(&cycle_count_q)) begin
                        cycle_count_d = cycle_count_q + 32'd1;
                    end
                end
                StDone: begin
                end
                default: begin
                    state_d = StHold;
                end
            endcase
        end
    end

    assign bus.soc_rst_n    = soc_rst_n_q;
    assign bus.running      = running_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.fail         = fail_q;
    assign bus.timeout      = timeout_q;
    assign bus.cycle_count  = cycle_count_q;
    assign bus.change_count = change_count_q;
    assign bus.last_leds    = last_leds_q;

endmodule

// File: tb/tb_soc_test_supervisor.sv
// Self-checking bench for soc_test_supervisor: directed scenarios plus random
// LED sequences scored against a window-based reference model.
module tb_soc_test_supervisor;

    localparam int unsigned LW    = 8;
    localparam int unsigned CW    = 16;
    localparam int unsigned RC    = 3;
    localparam int unsigned TC    = 20;
    localparam int unsigned SC    = 4;
    localparam int          SEQ_N = 32;
    localparam logic [7:0]  PASS_V = 8'hAA;
    localparam logic [7:0]  FAIL_V = 8'hFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    soc_test_supervisor_if #(.LED_WIDTH(LW), .COUNT_WIDTH(CW)) bus ();

    soc_test_supervisor #(
        .LED_WIDTH     (LW),
        .RESET_CYCLES  (RC),
        .TIMEOUT_CYCLES(TC),
        .STABLE_CYCLES (SC),
        .PASS_CODE     (PASS_V),
        .FAIL_CODE     (FAIL_V),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // seq[c] is the LED value presented during RUN cycle c; seq[0] stands for
    // the cleared sample register before the first RUN cycle.
    logic [7:0] seq [0:SEQ_N-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A verdict ends RUN cycle c when samples seq[c-1-SC .. c-1] (SC+1 of them)
    // all hold the same code; otherwise RUN ends on cycle TC with a timeout.
    function automatic void model(output int end_c, output int kind, output int chg);
        logic found;
        logic ok;
        found = 1'b0;
        end_c = TC;
        kind  = 2;
        for (int c = 1; c <= TC; c++) begin
            if (!found && (c - 1 - SC >= 1)) begin
                ok = 1'b1;
                for (int i = c - 1 - SC; i < c - 1; i++) begin
                    if (seq[i] != seq[i+1]) ok = 1'b0;
                end
                if (ok && (seq[c-1] == PASS_V || seq[c-1] == FAIL_V)) begin
                    found = 1'b1;
                    end_c = c;
                    kind  = (seq[c-1] == PASS_V) ? 0 : 1;
                end
            end
        end
        chg = 0;
        for (int i = 1; i < end_c; i++) begin
            if (seq[i] != seq[i-1]) chg++;
        end
    endfunction

    task automatic fill(input logic [7:0] v, input int from);
        for (int i = from; i < SEQ_N; i++) seq[i] = v;
    endtask

    task automatic gen_random();
        int         i;
        int         len;
        logic [7:0] v;
        seq[0] = 8'h00;
        i = 1;
        while (i < SEQ_N) begin
            case ($urandom_range(0, 3))
                0:       v = PASS_V;
                1:       v = FAIL_V;
                default: v = 8'($urandom);
            endcase
            len = $urandom_range(1, SC + 2);
            for (int j = 0; j < len; j++) begin
                if (i < SEQ_N) begin
                    seq[i] = v;
                    i++;
                end
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_soc_rst_n"}, 32'(bus.soc_rst_n), 0);
        check({tag, "_running"}, 32'(bus.running), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_flags"}, {29'd0, bus.pass, bus.fail, bus.timeout}, 0);
        check({tag, "_cycle_count"}, bus.cycle_count, 0);
        check({tag, "_change_count"}, 32'(bus.change_count), 0);
        check({tag, "_last_leds"}, 32'(bus.last_leds), 0);
    endtask

    // Counts negedges with soc_rst_n low starting at the current negedge.
    task automatic count_hold(input string tag);
        int n;
        n = 0;
        while (bus.soc_rst_n !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_hold_len"}, n, RC);
        check({tag, "_running_after_hold"}, 32'(bus.running), 1);
        check({tag, "_done_after_hold"}, 32'(bus.done), 0);
    endtask

    // Called at a negedge; holds start high for hold_len edges.
    task automatic restart(input string tag, input int hold_len);
        bus.start = 1'b1;
        @(negedge clk);
        check_cleared({tag, "_start"});
        repeat (hold_len - 1) @(negedge clk);
        check({tag, "_held_soc_rst_n"}, 32'(bus.soc_rst_n), 0);
        bus.start = 1'b0;
        count_hold(tag);
    endtask

    // Called at the negedge inside RUN cycle 1.
    task automatic run_test(input string tag);
        int end_c;
        int kind;
        int chg;
        int obs_end;
        model(end_c, kind, chg);
        obs_end = -1;
        for (int c = 1; c <= TC + 3; c++) begin
            if (obs_end < 0) begin
                if (bus.done === 1'b1) begin
                    obs_end = c - 1;
                end else begin
                    bus.leds = seq[c];
                    @(negedge clk);
                end
            end
        end
        check({tag, "_end_cycle"}, obs_end, end_c);
        check({tag, "_pass"}, 32'(bus.pass), (kind == 0) ? 1 : 0);
        check({tag, "_fail"}, 32'(bus.fail), (kind == 1) ? 1 : 0);
        check({tag, "_timeout"}, 32'(bus.timeout), (kind == 2) ? 1 : 0);
        check({tag, "_running"}, 32'(bus.running), 0);
        check({tag, "_soc_rst_n"}, 32'(bus.soc_rst_n), 1);
        check({tag, "_cycle_count"}, bus.cycle_count, end_c - 1);
        check({tag, "_change_count"}, 32'(bus.change_count), chg);
        check({tag, "_last_leds"}, 32'(bus.last_leds), 32'(seq[end_c-1]));
        // Everything must stay frozen while the LEDs keep moving.
        bus.leds = 8'h5A;
        repeat (2) @(negedge clk);
        bus.leds = PASS_V;
        repeat (2) @(negedge clk);
        check({tag, "_frozen_done"}, 32'(bus.done), 1);
        check({tag, "_frozen_change"}, 32'(bus.change_count), chg);
        check({tag, "_frozen_last"}, 32'(bus.last_leds), 32'(seq[end_c-1]));
        check({tag, "_frozen_cycles"}, bus.cycle_count, end_c - 1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.leds  = 8'h00;
        for (int i = 0; i < SEQ_N; i++) seq[i] = 8'h00;

        #12;
        check_cleared("reset");

        // Power-on: reset sequence, then a pass after 01, 02, AA.
        @(negedge clk);
        rst_n = 1'b1;
        count_hold("por");
        check("por_flags", {29'd0, bus.pass, bus.fail, bus.timeout}, 0);
        check("por_cycle_count", bus.cycle_count, 0);
        seq[0] = 8'h00; seq[1] = 8'h01; seq[2] = 8'h02;
        fill(PASS_V, 3);
        run_test("pass_seq");

        // Start from DONE; pass code interrupted by a one-cycle glitch.
        restart("rs1", 1);
        seq[1] = PASS_V; seq[2] = PASS_V; seq[3] = 8'h55;
        fill(PASS_V, 4);
        run_test("glitch");

        // Fail verdict lands exactly on the last RUN cycle.
        restart("rs2", 1);
        for (int i = 1; i < 15; i++) seq[i] = 8'h33;
        fill(FAIL_V, 15);
        run_test("fail_at_limit");

        // Non-code value held forever: timeout.
        restart("rs3", 1);
        fill(8'h12, 1);
        run_test("timeout");

        // Start held several cycles keeps the block in HOLD.
        restart("rs4", 4);
        fill(8'h00, 1);
        run_test("idle_zero");

        for (int r = 0; r < 10; r++) begin
            restart($sformatf("rnd%0d_rs", r), 1 + (r % 3));
            gen_random();
            run_test($sformatf("rnd%0d", r));
        end

        // Asynchronous reset in the middle of a run.
        restart("rs5", 1);
        bus.leds = 8'h21;
        repeat (3) @(negedge clk);
        bus.leds = 8'h22;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("async");
        @(negedge clk);
        rst_n = 1'b1;
        count_hold("async_rel");
        seq[0] = 8'h00; seq[1] = 8'h07;
        fill(PASS_V, 2);
        run_test("after_async");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
